md_unit: RTL and testbench

Parametrised multiply/divide unit for the pipelined MIPS CPU, sitting beside the EX-stage ALU and owning the architectural HI/LO registers. It performs signed/unsigned multiply, divide and multiply-accumulate/subtract with configurable operand width and per-class latency. It asserts `busy` so hazard logic can stall dependent instructions. It also supports an in-flight cancel for exception flushes.

---
 rtl/md_unit_if.sv | 26 ++
 rtl/md_unit.sv | 132 +++++++++++++
 tb/tb_md_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Multiply/divide unit bus: launch/op/operands and mthi/mtlo writes in, HI/LO and status out.
interface md_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic             cancel;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, hi_we, lo_we, cancel,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, cancel,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/md_unit.sv
// MIPS multiply/divide unit owning HI/LO; busy for MULT_CYCLES or DIV_CYCLES after start,
// result and one-cycle done follow; the CPU must stall on busy (start/hi_we/lo_we ignored in RUN).
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  md_unit_if.slave mdu
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int W2   = 2 * WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic [W2-1:0]    a_ext, b_ext, prod, mul_res;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  // Arithmetic on latched operands; op[0] selects unsigned, op[2] accumulate, op[1] sub/div.
  always_comb begin
    a_ext = op_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_ext = op_q[0] ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod  = a_ext * b_ext;
    if (!op_q[2])
      mul_res = prod;
    else if (op_q[1])
      mul_res = acc_q - prod;
    else
      mul_res = acc_q + prod;

    a_neg = ~op_q[0] & a_q[WIDTH-1];
    b_neg = ~op_q[0] & b_q[WIDTH-1];
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;
    q_mag = '0;
    r_mag = '0;
    // Most-negative / -1 falls out naturally: magnitude 2^(W-1) reinterprets as most-negative.
    if (b_q == '0) begin
      quot = '1;
      rem  = a_q;
    end else begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
      quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
      rem   = a_neg ? -r_mag : r_mag;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mdu.start) begin
          a_d     = mdu.a;
          b_d     = mdu.b;
          op_d    = mdu.op;
          acc_d   = mdu.op[2] ? {hi_q, lo_q} : '0;
          cnt_d   = (mdu.op[2:1] == 2'b01) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_d = RUN;
        end else begin
          if (mdu.hi_we) hi_d = mdu.a;
          if (mdu.lo_we) lo_d = mdu.a;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (mdu.cancel) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(1)) begin
          if (op_q[2:1] == 2'b01) begin
            hi_d = rem;
            lo_d = quot;
          end else begin
            hi_d = mul_res[W2-1:WIDTH];
            lo_d = mul_res[WIDTH-1:0];
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;
  assign mdu.busy = (state_q == RUN);
  assign mdu.done = done_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed-vector bench for md_unit with hand-computed HI/LO results.
module tb_md_unit;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  md_unit_if #(.WIDTH(32)) mdu ();

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch an op and wait for completion; leaves the bench in the done cycle.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int n, input string tag);
    int cyc;
    mdu.start = 1'b1;
    mdu.op    = op;
    mdu.a     = a;
    mdu.b     = b;
    tick();
    mdu.start = 1'b0;
    mdu.a     = '0;
    mdu.b     = '0;
    cyc = 0;
    while (mdu.busy && cyc < 100) begin
      cyc++;
      tick();
    end
    chk({tag, " busy_cycles"}, 32'(cyc), 32'(n));
    chk({tag, " done"}, 32'(mdu.done), 32'd1);
  endtask

  task automatic res(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    chk({tag, " hi"}, mdu.hi, hi);
    chk({tag, " lo"}, mdu.lo, lo);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    mdu.start  = 1'b0;
    mdu.op     = 3'b000;
    mdu.a      = '0;
    mdu.b      = '0;
    mdu.hi_we  = 1'b0;
    mdu.lo_we  = 1'b0;
    mdu.cancel = 1'b0;
    #22;
    chk("rst busy", 32'(mdu.busy), 32'd0);
    chk("rst done", 32'(mdu.done), 32'd0);
    res("rst", 32'h0, 32'h0);
    reset = 1'b1;
    tick();

    do_op(3'b000, 32'hFFFFFFFD, 32'd5, 5, "mult");
    res("mult", 32'hFFFFFFFF, 32'hFFFFFFF1);
    tick();
    chk("mult done_width", 32'(mdu.done), 32'd0);
    res("mult hold", 32'hFFFFFFFF, 32'hFFFFFFF1);

    do_op(3'b001, 32'hFFFFFFFF, 32'd2, 5, "multu");
    res("multu", 32'h00000001, 32'hFFFFFFFE);
    // Back-to-back: next start issued in the done cycle.
    do_op(3'b010, 32'hFFFFFFF9, 32'd2, 10, "div");
    res("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op(3'b010, 32'd7, 32'hFFFFFFFE, 10, "div_pos_neg");
    res("div_pos_neg", 32'h00000001, 32'hFFFFFFFD);
    do_op(3'b011, 32'd7, 32'd0, 10, "divu0");
    res("divu0", 32'h00000007, 32'hFFFFFFFF);
    do_op(3'b010, 32'hFFFFFFFB, 32'd0, 10, "div0");
    res("div0", 32'hFFFFFFFB, 32'hFFFFFFFF);
    do_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 10, "div_ovf");
    res("div_ovf", 32'h00000000, 32'h80000000);
    do_op(3'b011, 32'hFFFFFFFF, 32'h10, 10, "divu");
    res("divu", 32'h0000000F, 32'h0FFFFFFF);
    tick();

    mdu.hi_we = 1'b1;
    mdu.lo_we = 1'b1;
    mdu.a     = 32'h12345678;
    tick();
    res("mthilo", 32'h12345678, 32'h12345678);
    mdu.hi_we = 1'b0;
    mdu.a     = 32'hFFFFFFFF;
    mdu.cancel = 1'b1;
    tick();
    mdu.cancel = 1'b0;
    mdu.lo_we = 1'b0;
    mdu.hi_we = 1'b1;
    mdu.a     = 32'h0;
    tick();
    mdu.hi_we = 1'b0;
    res("mtlo_mthi", 32'h0, 32'hFFFFFFFF);

    do_op(3'b101, 32'd1, 32'd1, 5, "maddu");
    res("maddu", 32'h1, 32'h0);
    do_op(3'b110, 32'd1, 32'd1, 5, "msub");
    res("msub", 32'h0, 32'hFFFFFFFF);
    do_op(3'b100, 32'hFFFFFFFF, 32'd1, 5, "madd");
    res("madd", 32'h0, 32'hFFFFFFFE);
    do_op(3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, "msubu");
    res("msubu", 32'h00000002, 32'hFFFFFFFD);
    tick();

    // start takes priority over hi_we/lo_we in IDLE.
    mdu.start = 1'b1;
    mdu.op    = 3'b001;
    mdu.a     = 32'd3;
    mdu.b     = 32'd4;
    mdu.hi_we = 1'b1;
    mdu.lo_we = 1'b1;
    tick();
    mdu.start = 1'b0;
    mdu.hi_we = 1'b0;
    mdu.lo_we = 1'b0;
    res("prio midrun", 32'h00000002, 32'hFFFFFFFD);
    repeat (5) tick();
    chk("prio done", 32'(mdu.done), 32'd1);
    res("prio", 32'h0, 32'h0000000C);

    // Cancel in the 4th busy cycle; start/hi_we while busy are ignored.
    mdu.start = 1'b1;
    mdu.op    = 3'b011;
    mdu.a     = 32'd100;
    mdu.b     = 32'd7;
    tick();
    mdu.start = 1'b0;
    tick();
    tick();
    mdu.start = 1'b1;
    mdu.op    = 3'b000;
    mdu.hi_we = 1'b1;
    mdu.a     = 32'hDEADBEEF;
    tick();
    mdu.start = 1'b0;
    mdu.hi_we = 1'b0;
    chk("cancel still_busy", 32'(mdu.busy), 32'd1);
    res("cancel ignore_we", 32'h0, 32'h0000000C);
    mdu.cancel = 1'b1;
    tick();
    mdu.cancel = 1'b0;
    chk("cancel busy", 32'(mdu.busy), 32'd0);
    chk("cancel done", 32'(mdu.done), 32'd0);
    res("cancel", 32'h0, 32'h0000000C);
    repeat (8) tick();
    chk("cancel late_busy", 32'(mdu.busy), 32'd0);
    res("cancel late", 32'h0, 32'h0000000C);

    // Asynchronous reset mid-run.
    mdu.start = 1'b1;
    mdu.op    = 3'b000;
    mdu.a     = 32'd6;
    mdu.b     = 32'd7;
    tick();
    mdu.start = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("arst busy", 32'(mdu.busy), 32'd0);
    chk("arst done", 32'(mdu.done), 32'd0);
    res("arst", 32'h0, 32'h0);
    #2;
    reset = 1'b1;
    tick();
    chk("arst idle", 32'(mdu.busy), 32'd0);
    do_op(3'b000, 32'hFFFFFFFA, 32'd7, 5, "mult_after_rst");
    res("mult_after_rst", 32'hFFFFFFFF, 32'hFFFFFFD6);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
